// File: rtl/lc3_ctrl_pkg.sv
// Shared types and encodings for the LC3 pipeline controller.
// Holds the controller state set, opcode values and memory-phase codes.
package lc3_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST     = 3'd0,
    ST_FILL0   = 3'd1,
    ST_FILL1   = 3'd2,
    ST_FILL2   = 3'd3,
    ST_RUN     = 3'd4,
    ST_MEM_IND = 3'd5,
    ST_MEM_RW  = 3'd6,
    ST_BR_WAIT = 3'd7
  } state_t;

  localparam logic [3:0] OP_BR   = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_JSR  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_LDR  = 4'h6;
  localparam logic [3:0] OP_STR  = 4'h7;
  localparam logic [3:0] OP_RTI  = 4'h8;
  localparam logic [3:0] OP_NOT  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_STI  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_RES  = 4'hD;
  localparam logic [3:0] OP_LEA  = 4'hE;
  localparam logic [3:0] OP_TRAP = 4'hF;

  localparam logic [1:0] MS_READ  = 2'd0;
  localparam logic [1:0] MS_IND   = 2'd1;
  localparam logic [1:0] MS_WRITE = 2'd2;
  localparam logic [1:0] MS_IDLE  = 2'd3;

endpackage

// File: rtl/lc3_op_class.sv
// Classifies an LC3 instruction by the pipeline hazards it creates.
// Only the opcode field matters; operand bits are deliberately ignored.
module lc3_op_class
  import lc3_ctrl_pkg::*;
(
  input  logic [15:0] ir,
  output logic        is_load,
  output logic        is_store,
  output logic        is_indirect,
  output logic        is_ctrl
);

  logic [3:0] op_s;
  logic       unused_operand_s;

  assign op_s             = ir[15:12];
  assign unused_operand_s = ^ir[11:0];

  // Opcode decode into hazard classes
  always_comb begin
    is_load     = 1'b0;
    is_store    = 1'b0;
    is_indirect = 1'b0;
    is_ctrl     = 1'b0;
    case (op_s)
      OP_LD, OP_LDR: is_load = 1'b1;
      OP_LDI: begin
        is_load     = 1'b1;
        is_indirect = 1'b1;
      end
      OP_ST, OP_STR: is_store = 1'b1;
      OP_STI: begin
        is_store    = 1'b1;
        is_indirect = 1'b1;
      end
      OP_BR, OP_JMP: is_ctrl = 1'b1;
      default: is_ctrl = 1'b0;
    endcase
  end

endmodule

// File: rtl/lc3_pipe_ctrl.sv
// LC3 pipeline sequencer: drives stage enables, stalls for data-memory
// accesses and control transfers, and refills the pipe after a branch.
module lc3_pipe_ctrl
  import lc3_ctrl_pkg::*;
#(
  parameter int BR_PENALTY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  psr,
  input  logic        complete_data,
  output logic        enable_fetch,
  output logic        enable_updatePC,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic [1:0]  mem_state,
  output logic        br_taken
);

  localparam int              CNT_W    = $clog2(BR_PENALTY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BR_PENALTY - 1);

  state_t           state_r, state_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s;
  logic             is_load_r, is_load_nx_s;

  logic ex_load_s, ex_store_s, ex_ind_s, ex_ctrl_s;
  logic id_load_s, id_store_s, id_ind_s, id_ctrl_s;
  logic ex_jmp_s, br_cond_s, unused_class_s;

  lc3_op_class u_class_id (
    .ir          (IR),
    .is_load     (id_load_s),
    .is_store    (id_store_s),
    .is_indirect (id_ind_s),
    .is_ctrl     (id_ctrl_s)
  );

  lc3_op_class u_class_ex (
    .ir          (IR_Exec),
    .is_load     (ex_load_s),
    .is_store    (ex_store_s),
    .is_indirect (ex_ind_s),
    .is_ctrl     (ex_ctrl_s)
  );

  assign ex_jmp_s       = (IR_Exec[15:12] == OP_JMP);
  assign br_cond_s      = |(IR_Exec[11:9] & psr);
  assign unused_class_s = ex_ctrl_s ^ id_load_s ^ id_store_s ^ id_ind_s;

  // State, branch counter and latched access class
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_RST;
      cnt_r     <= '0;
      is_load_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      is_load_r <= is_load_nx_s;
    end
  end

  // Next-state selection; memory in execute outranks a control op in decode
  always_comb begin
    state_nx_s   = state_r;
    cnt_nx_s     = cnt_r;
    is_load_nx_s = is_load_r;
    case (state_r)
      ST_RST:   state_nx_s = ST_FILL0;
      ST_FILL0: state_nx_s = ST_FILL1;
      ST_FILL1: state_nx_s = ST_FILL2;
      ST_FILL2: state_nx_s = ST_RUN;
      ST_RUN: begin
        if (ex_load_s || ex_store_s) begin
          is_load_nx_s = ex_load_s;
          state_nx_s   = ex_ind_s ? ST_MEM_IND : ST_MEM_RW;
        end else if (id_ctrl_s) begin
          state_nx_s = ST_BR_WAIT;
          cnt_nx_s   = '0;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_MEM_IND: begin
        if (complete_data) state_nx_s = ST_MEM_RW;
        else               state_nx_s = ST_MEM_IND;
      end
      ST_MEM_RW: begin
        if (complete_data) state_nx_s = ST_RUN;
        else               state_nx_s = ST_MEM_RW;
      end
      ST_BR_WAIT: begin
        if (cnt_r == CNT_LAST) begin
          state_nx_s = ST_FILL0;
          cnt_nx_s   = '0;
        end else begin
          cnt_nx_s = cnt_r + CNT_W'(1);
        end
      end
      default: state_nx_s = ST_RST;
    endcase
  end

  // Output decode of the registered state
  always_comb begin
    enable_fetch     = 1'b0;
    enable_updatePC  = 1'b0;
    enable_decode    = 1'b0;
    enable_execute   = 1'b0;
    enable_writeback = 1'b0;
    mem_state        = MS_IDLE;
    br_taken         = 1'b0;
    case (state_r)
      ST_RST: mem_state = MS_IDLE;
      ST_FILL0: begin
        enable_fetch    = 1'b1;
        enable_updatePC = 1'b1;
      end
      ST_FILL1: begin
        enable_fetch    = 1'b1;
        enable_updatePC = 1'b1;
        enable_decode   = 1'b1;
      end
      ST_FILL2: begin
        enable_fetch    = 1'b1;
        enable_updatePC = 1'b1;
        enable_decode   = 1'b1;
        enable_execute  = 1'b1;
      end
      ST_RUN: begin
        enable_fetch     = 1'b1;
        enable_updatePC  = 1'b1;
        enable_decode    = 1'b1;
        enable_execute   = 1'b1;
        enable_writeback = 1'b1;
      end
      ST_MEM_IND: mem_state = MS_IND;
      ST_MEM_RW: begin
        mem_state = is_load_r ? MS_READ : MS_WRITE;
        if (is_load_r && complete_data) enable_writeback = 1'b1;
        else                            enable_writeback = 1'b0;
      end
      ST_BR_WAIT: begin
        if (cnt_r == '0) begin
          enable_execute   = 1'b1;
          enable_writeback = 1'b1;
          br_taken         = ex_jmp_s | br_cond_s;
        end else if (cnt_r == CNT_LAST) begin
          enable_updatePC = 1'b1;
        end else begin
          enable_updatePC = 1'b0;
        end
      end
      default: mem_state = MS_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lc3_pipe_ctrl.sv
// Randomized transaction-level bench for lc3_pipe_ctrl: each transaction
// predicts the full per-cycle enable pattern from the controller's rules.
module tb_lc3_pipe_ctrl;

  localparam int BRP = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] IR, IR_Exec;
  logic [2:0]  psr;
  logic        complete_data;
  logic        enable_fetch, enable_updatePC, enable_decode;
  logic        enable_execute, enable_writeback, br_taken;
  logic [1:0]  mem_state;
  logic [7:0]  obs_s;

  int n_total = 0;
  int n_pass  = 0;

  lc3_pipe_ctrl #(.BR_PENALTY(BRP)) dut (
    .clk              (clk),
    .rst              (rst),
    .IR               (IR),
    .IR_Exec          (IR_Exec),
    .psr              (psr),
    .complete_data    (complete_data),
    .enable_fetch     (enable_fetch),
    .enable_updatePC  (enable_updatePC),
    .enable_decode    (enable_decode),
    .enable_execute   (enable_execute),
    .enable_writeback (enable_writeback),
    .mem_state        (mem_state),
    .br_taken         (br_taken)
  );

  always #5 clk = ~clk;

  assign obs_s = {enable_fetch, enable_updatePC, enable_decode, enable_execute,
                  enable_writeback, mem_state, br_taken};

  // Expected output vector: {fetch,updatePC,decode,execute,writeback,mem_state,br_taken}
  function automatic logic [7:0] ev(logic f, logic u, logic d, logic e, logic w,
                                    logic [1:0] ms, logic bt);
    return {f, u, d, e, w, ms, bt};
  endfunction

  localparam logic [7:0] V_ZERO  = 8'b00000_11_0;
  localparam logic [7:0] V_FILL0 = 8'b11000_11_0;
  localparam logic [7:0] V_FILL1 = 8'b11100_11_0;
  localparam logic [7:0] V_FILL2 = 8'b11110_11_0;
  localparam logic [7:0] V_RUN   = 8'b11111_11_0;

  function automatic logic exp_br(logic [15:0] ir, logic [2:0] p);
    return (ir[15:12] == 4'hC) || ((ir[11:9] & p) != 3'b000);
  endfunction

  function automatic logic [15:0] rand_alu();
    logic [3:0] op;
    case ($urandom_range(0, 7))
      0: op = 4'h1;
      1: op = 4'h4;
      2: op = 4'h5;
      3: op = 4'h8;
      4: op = 4'h9;
      5: op = 4'hD;
      6: op = 4'hE;
      default: op = 4'hF;
    endcase
    return {op, 12'($urandom)};
  endfunction

  function automatic logic [15:0] rand_ctrl();
    return {($urandom_range(0, 1) == 1) ? 4'hC : 4'h0, 12'($urandom)};
  endfunction

  task automatic check_vec(string tag, logic [7:0] got, logic [7:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %b expected %b (f u d e w ms bt)", tag, $time, got, exp);
  endtask

  task automatic noise();
    IR            = 16'($urandom);
    IR_Exec       = 16'($urandom);
    psr           = 3'($urandom);
    complete_data = 1'($urandom);
  endtask

  // Inputs already driven (just after negedge); check, then advance a cycle.
  task automatic cyc(string tag, logic [7:0] exp);
    #1;
    check_vec(tag, obs_s, exp);
    @(negedge clk);
  endtask

  task automatic fill_seq();
    noise(); cyc("fill0", V_FILL0);
    noise(); cyc("fill1", V_FILL1);
    noise(); cyc("fill2", V_FILL2);
  endtask

  task automatic release_fill();
    rst = 1'b0;
    noise(); cyc("rst_release", V_ZERO);
    fill_seq();
  endtask

  task automatic do_reset(logic [7:0] exp_now, int hold);
    rst = 1'b1;
    noise();
    complete_data = 1'b0;
    cyc("rst_assert", exp_now);
    for (int i = 1; i < hold; i++) begin
      noise(); cyc("rst_hold", V_ZERO);
    end
    release_fill();
  endtask

  task automatic alu_txn();
    noise();
    IR      = rand_alu();
    IR_Exec = rand_alu();
    cyc("run_alu", V_RUN);
  endtask

  task automatic mem_txn(logic [3:0] opc, logic [15:0] ir_dec, int n_ind, int n_rw, bit rst_mid);
    logic       ld;
    logic [1:0] ms;
    ld = (opc == 4'h2) || (opc == 4'h6) || (opc == 4'hA);
    ms = ld ? 2'd0 : 2'd2;
    noise();
    IR      = ir_dec;
    IR_Exec = {opc, 12'($urandom)};
    cyc("run_mem", V_RUN);
    if (opc == 4'hA || opc == 4'hB) begin
      for (int i = 0; i < n_ind; i++) begin
        noise(); complete_data = 1'b0;
        cyc("mem_ind_wait", ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0));
      end
      noise(); complete_data = 1'b1;
      cyc("mem_ind_done", ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0));
    end
    if (rst_mid) begin
      do_reset(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ms, 1'b0), $urandom_range(1, 2));
    end else begin
      for (int i = 0; i < n_rw; i++) begin
        noise(); complete_data = 1'b0;
        cyc("mem_rw_wait", ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ms, 1'b0));
      end
      noise(); complete_data = 1'b1;
      cyc("mem_rw_done", ev(1'b0, 1'b0, 1'b0, 1'b0, ld, ms, 1'b0));
    end
  endtask

  task automatic br_txn(logic [15:0] ir_br, logic [2:0] p);
    noise();
    IR      = ir_br;
    IR_Exec = rand_alu();
    cyc("run_br", V_RUN);
    noise();
    IR_Exec = ir_br;
    psr     = p;
    cyc("br_b0", ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, exp_br(ir_br, p)));
    for (int i = 1; i < BRP - 1; i++) begin
      complete_data = 1'($urandom);
      cyc("br_mid", V_ZERO);
    end
    complete_data = 1'($urandom);
    cyc("br_last", ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0));
    fill_seq();
  endtask

  initial begin
    rst = 1'b1;
    noise();
    @(negedge clk);
    noise(); cyc("reset_state", V_ZERO);
    rst = 1'b0;
    IR = 16'h1021; IR_Exec = 16'h1021; psr = 3'b000; complete_data = 1'b0;
    cyc("rst_release", V_ZERO);
    IR = 16'h1021; cyc("fill0", V_FILL0);
    IR = 16'h1021; cyc("fill1", V_FILL1);
    IR = 16'h1021; cyc("fill2", V_FILL2);
    alu_txn();

    mem_txn(4'h2, 16'h1021, 0, 2, 1'b0);
    alu_txn();
    mem_txn(4'hB, 16'h1021, 0, 0, 1'b0);
    alu_txn();
    br_txn(16'h0A05, 3'b010);
    br_txn(16'h0A05, 3'b100);
    mem_txn(4'h6, 16'hC1C0, 1, 1, 1'b0);
    br_txn(16'hC1C0, 3'b000);
    mem_txn(4'h2, 16'h1021, 0, 2, 1'b1);
    alu_txn();

    for (int t = 0; t < 300; t++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 2) begin
        alu_txn();
      end else if (r <= 6) begin
        logic [3:0] opc;
        case ($urandom_range(0, 5))
          0: opc = 4'h2;
          1: opc = 4'h6;
          2: opc = 4'hA;
          3: opc = 4'h3;
          4: opc = 4'h7;
          default: opc = 4'hB;
        endcase
        mem_txn(opc, ($urandom_range(0, 1) == 1) ? rand_ctrl() : rand_alu(),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 9) == 0);
      end else if (r <= 8) begin
        br_txn(rand_ctrl(), 3'($urandom));
      end else begin
        do_reset(V_RUN, $urandom_range(1, 3));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
